// File: rtl/user_dr_pkg.sv
// USER data register sequencer: shared field offsets, capture word layout.
// Optional push counter enabled by USER_DR_PUSH_COUNT_EN.
package user_dr_pkg;

  localparam int PCNT_W = 8;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cap_rv_bit(input int result_w);
    return result_w;
  endfunction

  function automatic int cap_ovf_bit(input int result_w);
    return result_w + 1;
  endfunction

  function automatic int cap_lvl_lsb(input int result_w);
    return result_w + 2;
  endfunction

  function automatic int upd_flag_bit(input int data_w);
    return data_w;
  endfunction

  localparam int RESULT_W_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DR_W_DEF       = 32;
  localparam int LVL_W_DEF      = $clog2(FIFO_DEPTH_DEF) + 1;
  localparam int PAD_W_DEF      =
    DR_W_DEF - PCNT_W - RESULT_W_DEF - 2 - LVL_W_DEF;

  // Capture word layout for the default geometry, MSB first
  typedef struct packed {
    logic [PCNT_W-1:0]       pcount;
    logic [PAD_W_DEF-1:0]    pad;
    logic [LVL_W_DEF-1:0]    level;
    logic                    ovf;
    logic                    rvalid;
    logic [RESULT_W_DEF-1:0] result;
  } cap_word_t;

endpackage

// File: rtl/user_dr_if.sv
// USER data register sequencer: symbol stream toward the solver.
// Plain valid/ready handshake, no feature macros.
interface user_dr_if #(
  parameter int DATA_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/user_dr_fifo.sv
// USER data register sequencer: small synchronous symbol FIFO.
// Head reads as zero while empty; no feature macros.
module user_dr_fifo
  import user_dr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              rd;
  logic              wr;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));
  assign rd    = pop && !empty;
  // A pop frees the slot the write lands in when full
  assign wr    = push && (!full || rd);
  assign head  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + PTR_W'(1);
      if (rd) rptr <= rptr + PTR_W'(1);
      level <= level + LVL_W'(wr) - LVL_W'(rd);
    end
  end

endmodule

// File: rtl/user_dr_sequencer.sv
// USER data register sequencer: DR shift/capture/update and input queue.
// Define USER_DR_PUSH_COUNT_EN to report accepted pushes in the capture word.
module user_dr_sequencer
  import user_dr_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RESULT_W   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DR_W       = 32
) (
  input  logic                tck,
  input  logic                test_logic_reset,
  input  logic                tdi,
  output logic                tdo,
  input  logic                ir_is_user,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  user_dr_if.master           stream,
  input  logic                result_valid,
  input  logic [RESULT_W-1:0] result_data
);

  localparam int LVL_W    = lvl_w(FIFO_DEPTH);
  localparam int RV_BIT   = cap_rv_bit(RESULT_W);
  localparam int OVF_BIT  = cap_ovf_bit(RESULT_W);
  localparam int LVL_LSB  = cap_lvl_lsb(RESULT_W);
  localparam int FLAG_BIT = upd_flag_bit(DATA_W);

  logic [DR_W-1:0]   sr;
  logic [DR_W-1:0]   cap;
  logic              ovf;
  logic              push;
  logic              pop;
  logic              accept;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic [PCNT_W-1:0] pcount;

  assign tdo    = sr[0];
  assign push   = ir_is_user && update_dr && sr[FLAG_BIT];
  assign pop    = stream.out_valid && stream.out_ready;
  assign accept = push && (!full || pop);

  assign stream.out_valid = !empty;

  user_dr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (tck),
    .rst   (test_logic_reset),
    .push  (push),
    .pop   (pop),
    .din   (sr[DATA_W-1:0]),
    .level (level),
    .full  (full),
    .empty (empty),
    .head  (stream.out_data)
  );

  always_comb begin
    cap = '0;
    cap[RESULT_W-1:0]        = result_data;
    cap[RV_BIT]              = result_valid;
    cap[OVF_BIT]             = ovf;
    cap[LVL_LSB +: LVL_W]    = level;
    cap[DR_W-1 -: PCNT_W]    = pcount;
  end

  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      sr <= '0;
    end else if (ir_is_user) begin
      if (capture_dr)    sr <= cap;
      else if (shift_dr) sr <= {tdi, sr[DR_W-1:1]};
    end
  end

  // Capture reports the pre-clear flag, then clears it
  always_ff @(posedge tck) begin
    if (test_logic_reset)              ovf <= 1'b0;
    else if (ir_is_user && capture_dr) ovf <= 1'b0;
    else if (push && !accept)          ovf <= 1'b1;
  end

`ifdef USER_DR_PUSH_COUNT_EN
  always_ff @(posedge tck) begin
    if (test_logic_reset) pcount <= '0;
    else if (accept)      pcount <= pcount + PCNT_W'(1);
  end
`else
  assign pcount = '0;
`endif

endmodule

// File: tb/tb_user_dr_sequencer.sv
// Bench for user_dr_sequencer: directed steps plus random pushes vs a queue model.
// Follows USER_DR_PUSH_COUNT_EN for the expected push count field.
module tb_user_dr_sequencer;
  import user_dr_pkg::*;

  logic        tck = 1'b0;
  logic        rst = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        ir = 1'b1;
  logic        capture_dr = 1'b0;
  logic        shift_dr = 1'b0;
  logic        update_dr = 1'b0;
  logic        result_valid = 1'b0;
  logic [15:0] result_data = '0;

  user_dr_if #(.DATA_W(8)) ifc ();

  user_dr_sequencer dut (
    .tck              (tck),
    .test_logic_reset (rst),
    .tdi              (tdi),
    .tdo              (tdo),
    .ir_is_user       (ir),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .stream           (ifc),
    .result_valid     (result_valid),
    .result_data      (result_data)
  );

  always #5 tck = ~tck;

  int errors = 0;
  int checks = 0;

  logic [31:0] msr;
  logic [7:0]  mq[$];
  logic        movf;
  logic [7:0]  mcnt;
  logic [31:0] last_cap;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the current inputs, then compare
  task automatic tick();
    logic      pop;
    logic      push;
    cap_word_t c;
    if (rst) begin
      msr  = '0;
      mq.delete();
      movf = 1'b0;
      mcnt = '0;
    end else begin
      pop  = ifc.out_ready && (mq.size() != 0);
      push = ir && update_dr && msr[8];
      if (ir && capture_dr) begin
        c        = '0;
        c.result = result_data;
        c.rvalid = result_valid;
        c.ovf    = movf;
        c.level  = 3'(mq.size());
`ifdef USER_DR_PUSH_COUNT_EN
        c.pcount = mcnt;
`endif
        msr      = c;
        last_cap = c;
        movf     = 1'b0;
      end else if (ir && shift_dr) begin
        msr = {tdi, msr[31:1]};
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < 4) begin
          mq.push_back(msr[7:0]);
          mcnt++;
        end else begin
          movf = 1'b1;
        end
      end
    end
    @(posedge tck);
    #1;
    chk("tdo", 32'(tdo), 32'(msr[0]));
    chk("out_valid", 32'(ifc.out_valid), 32'(mq.size() != 0));
    chk("out_data", 32'(ifc.out_data),
        (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
  endtask

  task automatic shift_word(input logic [31:0] w, output logic [31:0] got);
    shift_dr = 1'b1;
    for (int i = 0; i < 32; i++) begin
      got[i] = tdo;
      tdi    = w[i];
      tick();
    end
    shift_dr = 1'b0;
  endtask

  task automatic update();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  task automatic capture_read(output logic [31:0] got);
    logic [31:0] r;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    r = $urandom;
    shift_word(r, got);
    chk("cap_word", got, last_cap);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [31:0] r;
    logic [31:0] junk;
    r = $urandom;
    shift_word({r[31:9], 1'b1, b}, junk);
    update();
  endtask

  logic [31:0] got;
  logic [31:0] r;
  logic [7:0]  b[5];
  logic [7:0]  exp_cnt;

  initial begin
    ifc.out_ready = 1'b0;
    msr  = '0;
    movf = 1'b0;
    mcnt = '0;
    last_cap = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_data", 32'(ifc.out_data), 32'd0);
    rst = 1'b0;

    // Reset mid-shift with a queued symbol
    r = $urandom;
    push_byte(r[7:0]);
    chk("pre_rst_valid", 32'(ifc.out_valid), 32'd1);
    shift_dr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tdi = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    tdi = 1'b1;
    tick();
    rst = 1'b0;
    shift_dr = 1'b0;
    chk("midrst_tdo", 32'(tdo), 32'd0);
    chk("midrst_valid", 32'(ifc.out_valid), 32'd0);
    capture_read(got);
    chk("midrst_ovf", 32'(got[17]), 32'd0);
    chk("midrst_lvl", 32'(got[20:18]), 32'd0);

    // Push 0x3C, then pop it
    push_byte(8'h3C);
    chk("push_valid", 32'(ifc.out_valid), 32'd1);
    chk("push_data", 32'(ifc.out_data), 32'h3C);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk("pop_valid", 32'(ifc.out_valid), 32'd0);

    // Status poll
    result_valid = 1'b1;
    result_data  = 16'h1234;
    capture_read(got);
    chk("poll_low", 32'(got[23:0]), 32'h011234);

    // Overflow: five pushes into a depth-4 queue
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      b[i] = r[7:0];
      push_byte(b[i]);
    end
    capture_read(got);
    chk("ovf_lvl", 32'(got[20:18]), 32'd4);
    chk("ovf_set", 32'(got[17]), 32'd1);
    capture_read(got);
    chk("ovf_clr", 32'(got[17]), 32'd0);
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain", 32'(ifc.out_data), 32'(b[i]));
      tick();
    end
    ifc.out_ready = 1'b0;
    chk("drain_empty", 32'(ifc.out_valid), 32'd0);

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      b[i] = r[7:0];
    end
    for (int i = 0; i < 4; i++) push_byte(b[i]);
    r = $urandom;
    shift_word({r[31:9], 1'b1, b[4]}, got);
    ifc.out_ready = 1'b1;
    update();
    ifc.out_ready = 1'b0;
    capture_read(got);
    chk("pp_lvl", 32'(got[20:18]), 32'd4);
    chk("pp_ovf", 32'(got[17]), 32'd0);
    ifc.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("pp_order", 32'(ifc.out_data), 32'(b[i]));
      tick();
    end
    ifc.out_ready = 1'b0;

    // Not selected: TAP pulses must be ignored
    r = $urandom;
    shift_word({r[31:9], 1'b1, r[7:0]}, got);
    ir = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdi = 1'($urandom);
      tick();
    end
    shift_dr = 1'b0;
    update();
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    chk("nouser_valid", 32'(ifc.out_valid), 32'd0);
    ir = 1'b1;
    update();
    chk("user_push", 32'(ifc.out_data), 32'(r[7:0]));
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;

    // 257 accepted pushes from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      r = $urandom;
      push_byte(r[7:0]);
    end
    tick();
    ifc.out_ready = 1'b0;
    capture_read(got);
`ifdef USER_DR_PUSH_COUNT_EN
    exp_cnt = 8'h01;
`else
    exp_cnt = 8'h00;
`endif
    chk("push_count", 32'(got[31:24]), 32'(exp_cnt));

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      ifc.out_ready = r[31];
      shift_word(r, got);
      ifc.out_ready = 1'($urandom);
      update();
      if (r[30:29] == 2'b00) begin
        result_valid = 1'($urandom);
        result_data  = 16'($urandom);
        capture_read(got);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
